// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the instruction fetch front end.
//   XLEN          - width of PC and instruction words
//   RESET_PC      - default word index fetched first after reset
//   fetch_state_t - fetch FSM state encoding
//   fetch_entry_t - one fetch buffer entry {instr, pc}
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        DONE
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
// Bundles the instruction-memory read port, the redirect request and the
// decode valid/ready handshake of the fetch unit.
//   master : fetch unit side (drives o_pc, o_valid, o_instr, o_instr_pc, o_done)
//   slave  : memory / decode / branch side (drives i_instruction, i_redirect,
//            i_redirect_pc, i_ready)
// ---------------------------------------------------------------------------
interface fetch_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] i_instruction;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_valid;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_instr_pc;
    logic            i_ready;
    logic            o_done;

    modport master (
        output o_pc,
        input  i_instruction,
        input  i_redirect,
        input  i_redirect_pc,
        output o_valid,
        output o_instr,
        output o_instr_pc,
        input  i_ready,
        output o_done
    );

    modport slave (
        input  o_pc,
        output i_instruction,
        output i_redirect,
        output i_redirect_pc,
        input  o_valid,
        input  o_instr,
        input  o_instr_pc,
        output i_ready,
        input  o_done
    );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO buffering fetched {instr, pc} entries.
//   i_clk, i_rst_n - clock, async active-low reset
//   push, push_data - write an entry at the tail
//   pop            - retire the head entry
//   flush          - discard all entries (takes priority over push/pop)
//   head_data      - registered copy of the head entry; holds its last value
//                    while the FIFO is empty
//   count, full, empty - occupancy
// ---------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_inc;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign head_inc = head + 1'b1;

    always_ff @(posedge i_clk) begin
        if (do_push && !flush) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            head_data <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head_inc;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            // head_data tracks the entry that will be at the head next cycle;
            // when nothing remains it keeps the last delivered entry.
            if (do_pop && count > CNT_W'(1)) begin
                head_data <= mem[head_inc];
            end else if (do_push && (empty || (do_pop && count == CNT_W'(1)))) begin
                head_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Presents a word-indexed PC to instruction
// memory, captures the same-cycle instruction into a fetch buffer and hands
// entries to decode over valid/ready. Redirects flush the buffer; fetching
// stops at the end of the program image.
//   i_clk, i_rst_n - clock, async active-low reset
//   bus (master)   - o_pc/i_instruction memory port, i_redirect/i_redirect_pc,
//                    o_valid/o_instr/o_instr_pc/i_ready decode handshake,
//                    o_done end-of-program flag
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                        DEPTH            = 2,
    parameter logic [cpu_pkg::XLEN-1:0]  RESET_PC         = cpu_pkg::RESET_PC,
    parameter int                        NUM_INSTRUCTIONS = 11
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    fetch_if.master bus
);
    import cpu_pkg::*;

    localparam int              CNT_W  = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] END_PC = XLEN'(NUM_INSTRUCTIONS);

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_inc;
    logic             done;
    fetch_entry_t     head;
    fetch_entry_t     new_entry;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             valid;
    logic             pop;
    logic             push;
    logic             drains_empty;

    assign valid  = ~empty;
    assign pop    = valid & bus.i_ready;
    assign pc_inc = pc + 1'b1;
    // The range check gates fetch even though FETCH should never hold an
    // out-of-range PC; it keeps index END_PC from ever being captured.
    assign push   = (state == FETCH) & ~bus.i_redirect & (pc < END_PC) & (~full | pop);

    assign drains_empty = (count == '0) | ((count == CNT_W'(1)) & pop);

    assign new_entry.instr = bus.i_instruction;
    assign new_entry.pc    = pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc    <= RESET_PC;
            state <= (RESET_PC >= END_PC) ? DONE : FETCH;
            done  <= 1'b0;
        end else if (bus.i_redirect) begin
            pc <= bus.i_redirect_pc;
            if (bus.i_redirect_pc < END_PC) begin
                state <= FETCH;
                done  <= 1'b0;
            end else begin
                state <= DONE;
                done  <= 1'b1;
            end
        end else begin
            case (state)
                FETCH: begin
                    done <= 1'b0;
                    if (push) begin
                        pc <= pc_inc;
                        if (pc_inc >= END_PC) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    done <= 1'b0;
                    if (drains_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= DONE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (push),
        .push_data (new_entry),
        .pop       (pop),
        .flush     (bus.i_redirect),
        .head_data (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.o_pc       = pc;
    assign bus.o_valid    = valid;
    assign bus.o_instr    = head.instr;
    assign bus.o_instr_pc = head.pc;
    assign bus.o_done     = done;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit: memory returns index*16; outputs are
// sampled on the falling edge, inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    fetch_if bus ();

    assign bus.i_instruction = bus.o_pc << 4;

    fetch_unit #(
        .DEPTH            (2),
        .RESET_PC         ('0),
        .NUM_INSTRUCTIONS (11)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_ready       = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", bus.o_pc, 32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_instr", bus.o_instr, 32'd0);
        chk("rst_instr_pc", bus.o_instr_pc, 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        rst_n = 1'b1;

        // Stream 0..10 with ready held high
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk("stream_valid", 32'(bus.o_valid), 32'd1);
            chk("stream_instr_pc", bus.o_instr_pc, 32'(k));
            chk("stream_instr", bus.o_instr, 32'(k * 16));
            chk("stream_done", 32'(bus.o_done), 32'd0);
            chk("stream_pc_le_11", 32'(bus.o_pc <= 32'd11), 32'd1);
        end
        @(negedge clk);
        chk("end_done", 32'(bus.o_done), 32'd1);
        chk("end_valid", 32'(bus.o_valid), 32'd0);
        chk("end_pc", bus.o_pc, 32'd11);
        chk("end_instr_hold", bus.o_instr, 32'h0a0);

        // Redirect out of DONE to 3
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'd3;
        @(negedge clk);
        bus.i_redirect = 1'b0;
        chk("rd3_done", 32'(bus.o_done), 32'd0);
        chk("rd3_valid", 32'(bus.o_valid), 32'd0);
        chk("rd3_pc", bus.o_pc, 32'd3);
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);
            chk("rd3_stream_valid", 32'(bus.o_valid), 32'd1);
            chk("rd3_stream_instr_pc", bus.o_instr_pc, 32'(k));
        end
        @(negedge clk);
        chk("rd3_end_done", 32'(bus.o_done), 32'd1);
        chk("rd3_end_pc", bus.o_pc, 32'd11);

        // Reach DRAIN with a full buffer, then redirect out of range
        bus.i_ready       = 1'b0;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'd9;
        @(negedge clk);
        bus.i_redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drain_valid", 32'(bus.o_valid), 32'd1);
        chk("drain_instr_pc", bus.o_instr_pc, 32'd9);
        chk("drain_pc", bus.o_pc, 32'd11);
        chk("drain_done", 32'(bus.o_done), 32'd0);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'd20;
        @(negedge clk);
        bus.i_redirect = 1'b0;
        chk("oor_valid", 32'(bus.o_valid), 32'd0);
        chk("oor_done", 32'(bus.o_done), 32'd1);
        chk("oor_pc", bus.o_pc, 32'd20);
        @(negedge clk);
        chk("oor_hold_pc", bus.o_pc, 32'd20);
        chk("oor_hold_valid", 32'(bus.o_valid), 32'd0);
        chk("oor_hold_done", 32'(bus.o_done), 32'd1);
        chk("oor_hold_instr_pc", bus.o_instr_pc, 32'd9);

        // Fill the buffer from 0, then async reset between edges
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'd0;
        @(negedge clk);
        bus.i_redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("full_valid", 32'(bus.o_valid), 32'd1);
        chk("full_pc", bus.o_pc, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_pc", bus.o_pc, 32'd0);
        chk("arst_instr_pc", bus.o_instr_pc, 32'd0);
        chk("arst_done", 32'(bus.o_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure for 5 cycles after the first valid
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.o_valid), 32'd1);
            chk("bp_instr_pc", bus.o_instr_pc, 32'd0);
            chk("bp_instr", bus.o_instr, 32'd0);
            chk("bp_pc", bus.o_pc, (i == 0) ? 32'd1 : 32'd2);
        end
        bus.i_ready = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk("bp_rel_valid", 32'(bus.o_valid), 32'd1);
            chk("bp_rel_instr_pc", bus.o_instr_pc, 32'(j));
        end
        chk("bp_rel_pc", bus.o_pc, 32'd5);

        // Redirect to 7 while full, popping head (pc 3) in the same cycle
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'd7;
        @(negedge clk);
        bus.i_redirect = 1'b0;
        chk("rd7_valid", 32'(bus.o_valid), 32'd0);
        chk("rd7_pc", bus.o_pc, 32'd7);
        @(negedge clk);
        chk("rd7_first_valid", 32'(bus.o_valid), 32'd1);
        chk("rd7_first_instr_pc", bus.o_instr_pc, 32'd7);
        chk("rd7_first_instr", bus.o_instr, 32'h070);
        @(negedge clk);
        chk("rd7_second_instr_pc", bus.o_instr_pc, 32'd8);
        chk("rd7_second_instr", bus.o_instr, 32'h080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
